usb_rx_word_sr: RTL and testbench

Parametrised serial-to-parallel word assembler for the USB RX path. It replaces the fixed 8-bit shift register.
- Shifts decoded NRZI bits in, skipping stuffed bits.
- Counts bits and latches each completed word into a holding register.
- Presents the held word through a valid/ack handshake to the RX controller and FIFO.
- Sits between the bit-unstuff/decode stage and the RX control FSM.

---
 rtl/usb_rx_word_sr.sv | 103 ++++++++++
 tb/tb_usb_rx_word_sr.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_word_sr.sv
// usb_rx_word_sr
// Serial-to-parallel word assembler for the USB RX path. Accepts decoded
// NRZI bits from the unstuff/decode stage, drops stuffed bits, and latches
// each completed DATA_W-bit word into a holding register. The RX control FSM
// and FIFO take the word through a valid/ack handshake.
//
// Parameters:
//   DATA_W     word width, 2..32
//   LSB_FIRST  1: first received bit ends up in bit 0; 0: in bit DATA_W-1
//   CNT_W      bit counter width, derived from DATA_W
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous reset, active-high
//   d_orig        decoded serial bit
//   shift_enable  bit strobe, d_orig valid this cycle
//   stuff_skip    strobed bit is a stuffed bit, discard it
//   clear         drop the partial word (SYNC detect / EOP)
//   data_ack      consumer has taken packet_data
//   partial_data  live shift register
//   bit_count     bits accepted into the current partial word
//   packet_data   last completed word
//   data_valid    packet_data holds an unconsumed word
//   overrun       sticky overrun flag
//
// Build option: define USB_RX_SR_OVERRUN_EN to implement the sticky overrun
// flag. Without it, overrun is tied to 0.

module usb_rx_word_sr #(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_orig,
  input  logic              shift_enable,
  input  logic              stuff_skip,
  input  logic              clear,
  input  logic              data_ack,
  output logic [DATA_W-1:0] partial_data,
  output logic [CNT_W-1:0]  bit_count,
  output logic [DATA_W-1:0] packet_data,
  output logic              data_valid,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic              accept;
  logic              complete;
  logic [DATA_W-1:0] shifted;

  // clear takes priority over a concurrent strobe, so it also blocks completion
  assign accept   = shift_enable & ~stuff_skip & ~clear;
  assign complete = accept & (bit_count == LAST_BIT);

  always_comb begin
    shifted = partial_data;
    if (LSB_FIRST)
      shifted = {d_orig, partial_data[DATA_W-1:1]};
    else
      shifted = {partial_data[DATA_W-2:0], d_orig};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      partial_data <= '0;
      bit_count    <= '0;
      packet_data  <= '0;
      data_valid   <= 1'b0;
    end else begin
      if (clear) begin
        partial_data <= '0;
        bit_count    <= '0;
      end else if (accept) begin
        partial_data <= shifted;
        bit_count    <= complete ? '0 : bit_count + CNT_W'(1);
      end

      // A completing word wins over a same-cycle ack, so it is never lost
      // to the handshake; an unacked word is simply overwritten.
      if (complete) begin
        packet_data <= shifted;
        data_valid  <= 1'b1;
      end else if (data_ack) begin
        data_valid  <= 1'b0;
      end
    end
  end

`ifdef USB_RX_SR_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (rst || clear)
      overrun <= 1'b0;
    else if (complete && data_valid && !data_ack)
      overrun <= 1'b1;
  end
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_usb_rx_word_sr.sv
// tb_usb_rx_word_sr
// Bench for usb_rx_word_sr. Instance a is 8-bit LSB-first and is tracked by
// a bit-history reference model; instance b is 16-bit MSB-first and is
// checked with hand-computed constants.

module tb_usb_rx_word_sr;

`ifdef USB_RX_SR_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance a: DATA_W=8, LSB_FIRST=1
  logic       a_rst = 1'b0, a_d = 1'b0, a_se = 1'b0, a_ss = 1'b0, a_clr = 1'b0, a_ack = 1'b0;
  logic [7:0] a_partial, a_packet;
  logic [2:0] a_cnt;
  logic       a_valid, a_ovr;

  usb_rx_word_sr #(.DATA_W(8), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(a_rst), .d_orig(a_d), .shift_enable(a_se),
    .stuff_skip(a_ss), .clear(a_clr), .data_ack(a_ack),
    .partial_data(a_partial), .bit_count(a_cnt), .packet_data(a_packet),
    .data_valid(a_valid), .overrun(a_ovr));

  // instance b: DATA_W=16, LSB_FIRST=0
  logic        b_rst = 1'b0, b_d = 1'b0, b_se = 1'b0, b_ss = 1'b0, b_clr = 1'b0, b_ack = 1'b0;
  logic [15:0] b_partial, b_packet;
  logic [3:0]  b_cnt;
  logic        b_valid, b_ovr;

  usb_rx_word_sr #(.DATA_W(16), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(b_rst), .d_orig(b_d), .shift_enable(b_se),
    .stuff_skip(b_ss), .clear(b_clr), .data_ack(b_ack),
    .partial_data(b_partial), .bit_count(b_cnt), .packet_data(b_packet),
    .data_valid(b_valid), .overrun(b_ovr));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model for instance a ----------------
  // Keeps the accepted bits since the last clear/reset; the partial word is
  // the most recent 8 of them (zero-filled), newest at bit 7.
  bit         m_hist[$];
  int         m_cnt   = 0;
  logic [7:0] m_packet = '0;
  bit         m_valid = 0;
  bit         m_ovr   = 0;

  function automatic logic [7:0] m_partial();
    logic [7:0] v = '0;
    int n = m_hist.size();
    for (int k = 0; k < n && k < 8; k++) v[7-k] = m_hist[n-1-k];
    return v;
  endfunction

  task automatic model_step(input bit se, input bit d, input bit ss,
                            input bit clr, input bit ack, input bit rst);
    bit complete = 0;
    if (rst) begin
      m_hist.delete(); m_cnt = 0; m_packet = '0; m_valid = 0; m_ovr = 0;
      return;
    end
    if (clr) begin
      m_hist.delete(); m_cnt = 0;
    end else if (se && !ss) begin
      m_hist.push_back(d);
      if (m_hist.size() > 8) void'(m_hist.pop_front());
      m_cnt++;
      if (m_cnt == 8) begin m_cnt = 0; complete = 1; end
    end
    if (complete) begin
      if (OVR_EN && m_valid && !ack) m_ovr = 1;
      m_packet = m_partial();
      m_valid  = 1;
    end else if (ack) begin
      m_valid = 0;
    end
    if (clr) m_ovr = 0;
  endtask

  // one clock on instance a, then compare every output with the model
  task automatic step_a(input bit se, input bit d, input bit ss,
                        input bit clr, input bit ack, input bit rst);
    a_se = se; a_d = d; a_ss = ss; a_clr = clr; a_ack = ack; a_rst = rst;
    @(posedge clk);
    model_step(se, d, ss, clr, ack, rst);
    #1;
    chk("a_partial", 32'(a_partial), 32'(m_partial()));
    chk("a_bit_count", 32'(a_cnt), 32'(m_cnt));
    chk("a_packet", 32'(a_packet), 32'(m_packet));
    chk("a_valid", 32'(a_valid), 32'(m_valid));
    chk("a_overrun", 32'(a_ovr), 32'(m_ovr));
    a_se = 0; a_ss = 0; a_clr = 0; a_ack = 0; a_rst = 0;
  endtask

  // word sent LSB first; ack optionally raised on the completing bit
  task automatic send_a(input logic [7:0] w, input bit ack_last);
    for (int i = 0; i < 8; i++) step_a(1, w[i], 0, 0, ack_last && i == 7, 0);
  endtask

  task automatic step_b(input bit se, input bit d, input bit rst);
    b_se = se; b_d = d; b_rst = rst;
    @(posedge clk);
    #1;
    b_se = 0; b_rst = 0;
  endtask

  typedef struct {
    bit se, d, ss, ack, rst;
    logic [7:0] packet;
    bit valid;
    int cnt;
  } vec_t;

  vec_t vecs[$];
  logic [15:0] pat;

  initial begin
    // tests 1 and 2: table of inputs with hand-derived expectations
    vecs.push_back('{0,0,0,0,1, 8'h00,0,0});
    vecs.push_back('{1,1,0,0,0, 8'h00,0,1});
    for (int i = 2; i <= 7; i++) vecs.push_back('{1,0,0,0,0, 8'h00,0,i});
    vecs.push_back('{1,0,0,0,0, 8'h01,1,0});
    vecs.push_back('{0,0,0,1,0, 8'h01,0,0});
    for (int i = 1; i <= 4; i++) vecs.push_back('{1,1,0,0,0, 8'h01,0,i});
    vecs.push_back('{1,0,1,0,0, 8'h01,0,4});
    vecs.push_back('{0,1,0,0,0, 8'h01,0,4});
    for (int i = 5; i <= 7; i++) vecs.push_back('{1,1,0,0,0, 8'h01,0,i});
    vecs.push_back('{1,1,0,0,0, 8'hFF,1,0});
    vecs.push_back('{0,0,0,1,0, 8'hFF,0,0});

    foreach (vecs[i]) begin
      step_a(vecs[i].se, vecs[i].d, vecs[i].ss, 0, vecs[i].ack, vecs[i].rst);
      chk($sformatf("vec%0d_packet", i), 32'(a_packet), 32'(vecs[i].packet));
      chk($sformatf("vec%0d_valid", i), 32'(a_valid), 32'(vecs[i].valid));
      chk($sformatf("vec%0d_cnt", i), 32'(a_cnt), 32'(vecs[i].cnt));
    end

    // test 3: held word survives clear; new word completes on 8th post-clear bit
    send_a(8'h5A, 0);
    chk("t3_held", 32'(a_packet), 32'h5A);
    for (int i = 0; i < 5; i++) step_a(1, 1, 0, 0, 0, 0);
    step_a(1, 1, 0, 1, 0, 0);
    chk("t3_clr_cnt", 32'(a_cnt), 0);
    chk("t3_clr_partial", 32'(a_partial), 0);
    chk("t3_clr_valid", 32'(a_valid), 1);
    for (int i = 0; i < 7; i++) step_a(1, (8'hA5 >> i) & 1, 0, 0, 0, 0);
    chk("t3_pre_packet", 32'(a_packet), 32'h5A);
    chk("t3_pre_valid", 32'(a_valid), 1);
    step_a(1, 1, 0, 0, 0, 0);
    chk("t3_packet", 32'(a_packet), 32'hA5);

    // test 4: completion wins over same-cycle ack
    step_a(0, 0, 0, 1, 1, 0);
    chk("t4_idle_valid", 32'(a_valid), 0);
    send_a(8'h3C, 0);
    chk("t4_first", 32'(a_packet), 32'h3C);
    send_a(8'hC3, 1);
    chk("t4_packet", 32'(a_packet), 32'hC3);
    chk("t4_valid", 32'(a_valid), 1);
    chk("t4_overrun", 32'(a_ovr), 0);

    // test 5: overrun sticky across ack, cleared by clear, then by rst
    step_a(0, 0, 0, 0, 1, 0);
    send_a(8'h11, 0);
    send_a(8'h22, 0);
    chk("t5_packet", 32'(a_packet), 32'h22);
    chk("t5_overrun", 32'(a_ovr), 32'(OVR_EN));
    step_a(0, 0, 0, 0, 1, 0);
    chk("t5_ack_valid", 32'(a_valid), 0);
    chk("t5_ack_overrun", 32'(a_ovr), 32'(OVR_EN));
    step_a(0, 0, 0, 1, 0, 0);
    chk("t5_clr_overrun", 32'(a_ovr), 0);
    send_a(8'h33, 0);
    send_a(8'h44, 0);
    chk("t5_overrun2", 32'(a_ovr), 32'(OVR_EN));
    step_a(1, 1, 0, 0, 0, 1);
    chk("t5_rst_overrun", 32'(a_ovr), 0);
    chk("t5_rst_valid", 32'(a_valid), 0);

    // randomized run against the model
    for (int i = 0; i < 3000; i++)
      step_a($urandom_range(3) != 0, $urandom_range(1), $urandom_range(7) == 0,
             $urandom_range(23) == 0, $urandom_range(3) == 0, $urandom_range(199) == 0);

    // test 6: 16-bit MSB-first instance, reset mid-word
    step_b(0, 0, 1);
    chk("t6_rst_packet", 32'(b_packet), 0);
    chk("t6_rst_overrun", 32'(b_ovr), 0);
    for (int i = 0; i < 7; i++) step_b(1, 1, 0);
    chk("t6_mid_cnt", 32'(b_cnt), 7);
    chk("t6_mid_partial", 32'(b_partial), 32'h007F);
    step_b(1, 1, 1);
    chk("t6_rst_partial", 32'(b_partial), 0);
    chk("t6_rst_cnt", 32'(b_cnt), 0);
    chk("t6_rst_valid", 32'(b_valid), 0);
    pat = 16'h8001;
    for (int i = 15; i >= 0; i--) begin
      step_b(1, pat[i], 0);
      if (i == 15) begin
        chk("t6_first_cnt", 32'(b_cnt), 1);
        chk("t6_first_partial", 32'(b_partial), 32'h0001);
      end
      if (i == 1) chk("t6_pre_valid", 32'(b_valid), 0);
    end
    chk("t6_packet", 32'(b_packet), 32'h8001);
    chk("t6_valid", 32'(b_valid), 1);
    chk("t6_cnt", 32'(b_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
